// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
// Holds the deserializer state encoding and the clog2 helper used for counter widths.
package uart_rx_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } rx_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Data-bit counter for one receive frame.
// Latches the clamped frame length on load and flags the terminal bit.
module rx_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int MAX_WIDTH = 8,
  parameter int CNT_W     = clog2(MAX_WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             load,
  input  logic             inc,
  input  logic [CNT_W-1:0] len_in,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] len,
  output logic             last
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_WIDTH);

  logic [CNT_W-1:0] len_clamped;

  // Zero and out-of-range lengths fall back to a full-width frame.
  always_comb begin
    len_clamped = len_in;
    if ((len_in == '0) || (len_in > MAX_LEN)) len_clamped = MAX_LEN;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
      len <= MAX_LEN;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
      len <= len_clamped;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == (len - CNT_W'(1)));

endmodule

// File: rtl/rx_frame_deserializer.sv
// Collects strobed receive bits into a parallel word with running parity.
// data_valid is a one-cycle pulse with no ready back-pressure; P_DATA and parity_acc stay stable until the next completed frame.
module rx_frame_deserializer
  import uart_rx_pkg::*;
#(
  parameter  int MAX_WIDTH = 8,
  localparam int CNT_W     = clog2(MAX_WIDTH + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 bit_strobe,
  input  logic                 sampled_bit,
  input  logic [CNT_W-1:0]     data_len,
  input  logic                 msb_first,
  output logic [MAX_WIDTH-1:0] P_DATA,
  output logic                 data_valid,
  output logic                 parity_acc,
  output logic                 busy,
  output rx_state_e            state_dbg
);

  rx_state_e            state_q, state_d;
  logic [MAX_WIDTH-1:0] shift_q, shift_d, word_ins;
  logic                 par_q, par_d;
  logic                 msb_q, msb_d;
  logic                 cnt_load, cnt_inc, cnt_last, done;
  logic [CNT_W-1:0]     cnt, len;
  int                   idx;

  rx_bit_counter #(
    .MAX_WIDTH (MAX_WIDTH),
    .CNT_W     (CNT_W)
  ) u_bit_counter (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (clear),
    .load   (cnt_load),
    .inc    (cnt_inc),
    .len_in (data_len),
    .cnt    (cnt),
    .len    (len),
    .last   (cnt_last)
  );

  // Shift register with the current sample dropped into its bit position.
  always_comb begin
    idx      = msb_q ? (int'(len) - int'(cnt) - 1) : int'(cnt);
    word_ins = shift_q;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (idx == i) word_ins[i] = sampled_bit;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    par_d    = par_q;
    msb_d    = msb_q;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    done     = 1'b0;
    if (clear) begin
      state_d = IDLE;
      shift_d = '0;
      par_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_d  = COLLECT;
            cnt_load = 1'b1;
            shift_d  = '0;
            par_d    = 1'b0;
            msb_d    = msb_first;
          end
        end
        COLLECT: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (bit_strobe) begin
            cnt_inc = 1'b1;
            shift_d = word_ins;
            par_d   = par_q ^ sampled_bit;
            if (cnt_last) begin
              done    = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      par_q      <= 1'b0;
      msb_q      <= 1'b0;
      P_DATA     <= '0;
      parity_acc <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      msb_q      <= msb_d;
      data_valid <= done;
      if (done) begin
        P_DATA     <= word_ins;
        parity_acc <= par_q ^ sampled_bit;
      end
    end
  end

  assign busy      = (state_q == COLLECT);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_rx_frame_deserializer.sv
// Self-checking bench for rx_frame_deserializer: directed frames, aborts, reset and random traffic.
// Expected words come from a bit-list model; a scoreboard queue pairs them with data_valid pulses.
module tb_rx_frame_deserializer;
  import uart_rx_pkg::*;

  localparam int MAX_WIDTH = 8;
  localparam int CNT_W     = 4;

  logic                 CLK         = 1'b0;
  logic                 RST         = 1'b1;
  logic                 enable      = 1'b0;
  logic                 clear       = 1'b0;
  logic                 bit_strobe  = 1'b0;
  logic                 sampled_bit = 1'b0;
  logic                 msb_first   = 1'b0;
  logic [CNT_W-1:0]     data_len    = '0;
  logic [MAX_WIDTH-1:0] P_DATA;
  logic                 data_valid;
  logic                 parity_acc;
  logic                 busy;
  rx_state_e            state_dbg;

  int n_vec  = 0;
  int n_miss = 0;

  logic [MAX_WIDTH:0]   exp_q[$];
  logic [MAX_WIDTH-1:0] ref_pdata = '0;
  logic                 ref_par   = 1'b0;

  rx_frame_deserializer #(.MAX_WIDTH(MAX_WIDTH)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .enable      (enable),
    .clear       (clear),
    .bit_strobe  (bit_strobe),
    .sampled_bit (sampled_bit),
    .data_len    (data_len),
    .msb_first   (msb_first),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .parity_acc  (parity_acc),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // Clock
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int eff_len(input int len_cfg);
    return ((len_cfg == 0) || (len_cfg > MAX_WIDTH)) ? MAX_WIDTH : len_cfg;
  endfunction

  // bits[i] is the i-th bit on the wire; returns {parity, word}.
  function automatic logic [MAX_WIDTH:0] model_frame(input int len_cfg, input bit msb,
                                                     input logic [15:0] bits);
    int                   n;
    logic [MAX_WIDTH-1:0] w;
    logic                 p;
    n = eff_len(len_cfg);
    w = '0;
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (msb) w[n-1-i] = bits[i];
      else     w[i]     = bits[i];
      p = p ^ bits[i];
    end
    return {p, w};
  endfunction

  // Scoreboard: every data_valid pulse must match the oldest predicted frame.
  always @(negedge CLK) begin
    logic [MAX_WIDTH:0] e;
    if (data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", data_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("sb_p_data", P_DATA, e[MAX_WIDTH-1:0]);
        check("sb_parity", parity_acc, e[MAX_WIDTH]);
        ref_pdata = e[MAX_WIDTH-1:0];
        ref_par   = e[MAX_WIDTH];
      end
    end
  end

  // Runs one complete frame; returns at the negedge where data_valid should be high.
  task automatic send_frame(input int len_cfg, input bit msb, input logic [15:0] bits,
                            input bit keep_en);
    int n;
    n = eff_len(len_cfg);
    data_len  = CNT_W'(len_cfg);
    msb_first = msb;
    enable    = 1'b1;
    @(posedge CLK); #1;
    check("busy_on_entry", busy, 1'b1);
    data_len  = CNT_W'($urandom_range(0, 15));
    msb_first = 1'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
      sampled_bit = bits[i];
      bit_strobe  = 1'b1;
      if (i == n - 1) exp_q.push_back(model_frame(len_cfg, msb, bits));
      @(posedge CLK); #1;
      bit_strobe  = 1'b0;
      sampled_bit = 1'($urandom_range(0, 1));
    end
    @(negedge CLK);
    check("valid_latency", data_valid, 1'b1);
    if (!keep_en) enable = 1'b0;
  endtask

  task automatic start_partial(input int nstrobes);
    data_len  = 4'd8;
    msb_first = 1'b0;
    enable    = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < nstrobes; i++) begin
      sampled_bit = 1'b1;
      bit_strobe  = 1'b1;
      @(posedge CLK); #1;
      bit_strobe  = 1'b0;
    end
  endtask

  task automatic abort_enable(input int nstrobes);
    start_partial(nstrobes);
    enable = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("abort_no_valid", data_valid, 1'b0);
    end
    check("abort_busy", busy, 1'b0);
    check("abort_hold_pdata", P_DATA, ref_pdata);
    check("abort_hold_parity", parity_acc, ref_par);
  endtask

  task automatic clear_with_strobe(input int nstrobes);
    start_partial(nstrobes);
    clear       = 1'b1;
    bit_strobe  = 1'b1;
    sampled_bit = 1'b1;
    @(posedge CLK); #1;
    clear      = 1'b0;
    bit_strobe = 1'b0;
    check("clear_busy", busy, 1'b0);
    check("clear_state", state_dbg, IDLE);
    check("clear_hold_pdata", P_DATA, ref_pdata);
  endtask

  task automatic reset_mid_frame(input int nstrobes);
    start_partial(nstrobes);
    RST = 1'b0;
    #1;
    check("rst_p_data", P_DATA, '0);
    check("rst_parity", parity_acc, 1'b0);
    check("rst_valid", data_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    ref_pdata = '0;
    ref_par   = 1'b0;
    enable    = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      check("rst_no_valid", data_valid, 1'b0);
    end
  endtask

  task automatic idle_noise();
    enable = 1'b0;
    repeat (4) begin
      @(posedge CLK); #1;
      bit_strobe  = 1'($urandom_range(0, 1));
      sampled_bit = 1'($urandom_range(0, 1));
    end
    @(posedge CLK); #1;
    bit_strobe = 1'b0;
    @(negedge CLK);
    check("idle_busy", busy, 1'b0);
    check("idle_hold_pdata", P_DATA, ref_pdata);
  endtask

  initial begin
    // Reset
    #2 RST = 1'b0;
    #1;
    check("reset_p_data", P_DATA, '0);
    check("reset_valid", data_valid, 1'b0);
    check("reset_parity", parity_acc, 1'b0);
    check("reset_busy", busy, 1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;

    send_frame(8, 1'b0, 16'h00A5, 1'b0);
    check("lsb_a5", P_DATA, 8'hA5);
    check("lsb_a5_par", parity_acc, 1'b0);
    send_frame(8, 1'b1, 16'h00A5, 1'b0);
    check("msb_a5", P_DATA, 8'hA5);
    send_frame(8, 1'b1, 16'h0003, 1'b0);
    check("msb_c0", P_DATA, 8'hC0);
    check("msb_c0_par", parity_acc, 1'b0);
    send_frame(5, 1'b0, 16'h0017, 1'b0);
    check("len5_17", P_DATA, 8'h17);
    check("len5_upper_zero", P_DATA[7:5], 3'b000);

    abort_enable(3);
    check("abort_keeps_17", P_DATA, 8'h17);

    send_frame(5, 1'b0, 16'h0017, 1'b0);
    clear_with_strobe(3);
    check("clear_keeps_17", P_DATA, 8'h17);
    send_frame(8, 1'b0, 16'h005A, 1'b0);
    check("after_clear_5a", P_DATA, 8'h5A);

    reset_mid_frame(4);
    send_frame(8, 1'b0, 16'h003C, 1'b0);
    check("after_rst_3c", P_DATA, 8'h3C);

    send_frame(0, 1'b0, 16'h0081, 1'b0);
    check("len0_full", P_DATA, 8'h81);

    idle_noise();

    for (int k = 0; k < 24; k++) begin
      bit keep;
      keep = 1'($urandom_range(0, 1));
      send_frame(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 16'($urandom), keep);
      if (!keep && ($urandom_range(0, 3) == 0)) idle_noise();
    end

    enable = 1'b0;
    repeat (3) @(negedge CLK);
    check("scoreboard_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rx_frame_deserializer.md
RX_FRAME_DESERIALIZER -- requirements
Module: rx_frame_deserializer

Interface
REQ-001 Parameter MAX_WIDTH, default 8, maximum data bits per frame; legal range 5..16.
REQ-002 Localparam CNT_W, value clog2(MAX_WIDTH+1), width of the bit counter and of data_len.
REQ-003 CLK  input  1  system clock; all state updates occur on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  frame-active qualifier from the RX FSM; high for the whole data phase.
REQ-006 clear  input  1  synchronous frame restart.
REQ-007 bit_strobe  input  1  one-cycle pulse marking the sample point of the current bit.
REQ-008 sampled_bit  input  1  majority-voted bit value; valid while bit_strobe is high.
REQ-009 data_len  input  CNT_W  configured data bits per frame.
REQ-010 msb_first  input  1  bit order: 0 = LSB first, 1 = MSB first.
REQ-011 P_DATA  output  MAX_WIDTH  last completed frame word, registered.
REQ-012 data_valid  output  1  one-cycle pulse indicating that P_DATA has been updated.
REQ-013 parity_acc  output  1  XOR of all data bits of the last completed frame, registered.
REQ-014 busy  output  1  high while in state COLLECT.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and COLLECT.
REQ-016 IDLE->COLLECT when enable=1 and clear=0; on entry, bit count=0, shift register=0, running parity=0, and data_len and msb_first are latched.
REQ-017 A latched data_len of 0 or greater than MAX_WIDTH SHALL be treated as MAX_WIDTH; values 1..MAX_WIDTH are used as given.
REQ-018 In COLLECT, each bit_strobe SHALL write sampled_bit at index cnt (LSB-first) or at index len-1-cnt (MSB-first), increment cnt, and XOR sampled_bit into the running parity.
REQ-019 Bits at indices at or above len SHALL be 0 in P_DATA.
REQ-020 On the bit_strobe for which cnt == len-1, the following apply in the next cycle:
 - P_DATA is loaded with the completed word.
 - parity_acc is loaded with the running parity.
 - data_valid pulses for exactly one cycle.
 - The FSM returns to IDLE.
REQ-021 Latency from the final bit_strobe to data_valid SHALL be exactly 1 clock.
REQ-022 P_DATA and parity_acc SHALL hold their values until the next completed frame; aborted frames SHALL never modify them.
REQ-023 If enable falls in COLLECT before completion, the frame is aborted: the FSM goes to IDLE and data_valid is not asserted.
REQ-024 If clear=1 in any state, the FSM goes to IDLE and cnt, the shift register and the running parity are zeroed.
REQ-025 If clear and bit_strobe occur in the same cycle, clear wins and the bit is discarded.
REQ-026 bit_strobe SHALL be ignored in IDLE.
REQ-027 Changes to data_len or msb_first during COLLECT SHALL NOT affect the frame in progress.
REQ-028 If enable stays high after completion, the block SHALL re-enter COLLECT on the next cycle, ready for a back-to-back frame.

Reset
REQ-029 On RST=0, the following take effect immediately:
 - state=IDLE.
 - cnt=0, shift register=0, running parity=0.
 - P_DATA=0, parity_acc=0, data_valid=0, busy=0.
REQ-030 A reset asserted mid-frame SHALL discard the frame with no data_valid pulse.

Structure
REQ-031 The state encodings (IDLE=0, COLLECT=1) and a clog2 constant function SHALL reside in the shared package uart_rx_pkg.
REQ-032 The bit counter, including length clamping and the terminal-count flag, SHALL be the sub-module rx_bit_counter; all other logic SHALL stay in rx_frame_deserializer.

Verification
REQ-033 LSB-first, len=8, bits 1,0,1,0,0,1,0,1 -> P_DATA=0xA5, parity_acc=0, data_valid one cycle after the 8th strobe.
REQ-034 MSB-first, len=8, same bits -> P_DATA=0xA5 bit-reversed = 0xA5 (palindrome); repeat with bits 1,1,0,0,0,0,0,0 -> P_DATA=0xC0, parity_acc=0.
REQ-035 LSB-first, len=5, bits 1,1,1,0,1 -> P_DATA=0x17, parity_acc=0; P_DATA[7:5]=0.
REQ-036 Abort checks, both starting from P_DATA=0x17:
 - enable dropped after 3 strobes -> no data_valid, P_DATA stays 0x17.
 - clear with a simultaneous strobe -> the bit is discarded and the next frame starts at cnt=0.
REQ-037 RST asserted after 4 strobes -> all outputs 0 immediately; the next full frame 0x3C completes correctly.
REQ-038 data_len=0 with MAX_WIDTH=8 -> the frame completes after 8 strobes.
